adc_frame_capture: RTL and testbench

ADC_FRAME_CAPTURE -- requirements
Module: adc_frame_capture

---
 rtl/adc_frame_capture.sv | 165 ++++++++++++++++
 tb/tb_adc_frame_capture.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_capture.sv
// Purpose: reads three XADC aux channels over DRP per eoc and publishes vout plus a saturated flying-cap difference.
// Latency: den one cycle after eoc; each drdy captured on its own edge; frame_valid one cycle after the third capture.
// Backpressure: none; eoc outside IDLE is dropped and flagged, a missing drdy times out and drops the partial frame.
module adc_frame_capture #(
    parameter logic [6:0] ADDR_CH0       = 7'h17,
    parameter logic [6:0] ADDR_CH1       = 7'h1E,
    parameter logic [6:0] ADDR_CH2       = 7'h1F,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        eoc,
    input  logic        drdy,
    input  logic [15:0] do_in,
    input  logic        clear_err,
    output logic        den,
    output logic [6:0]  daddr,
    output logic [15:0] vout,
    output logic [15:0] vfc,
    output logic        frame_valid,
    output logic        err_timeout,
    output logic        err_overrun
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    state_t         state_q, state_d;
    logic [1:0]     ch_q, ch_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    raw0_q, raw0_d;
    logic [15:0]    raw1_q, raw1_d;
    logic [15:0]    raw2_q, raw2_d;
    logic [15:0]    vout_q, vout_d;
    logic [15:0]    vfc_q, vfc_d;
    logic           den_q, den_d;
    logic           fv_q, fv_d;
    logic           err_to_q, err_to_d;
    logic           err_ov_q, err_ov_d;

    // Channel address decode; ch only changes on the capture edge, so daddr is stable across a transaction.
    always_comb begin
        case (ch_q)
            2'd1:    daddr = ADDR_CH1;
            2'd2:    daddr = ADDR_CH2;
            default: daddr = ADDR_CH0;
        endcase
    end

    // Next-state logic: DRP sequencing, capture, commit and sticky error flags.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        raw0_d   = raw0_q;
        raw1_d   = raw1_q;
        raw2_d   = raw2_q;
        vout_d   = vout_q;
        vfc_d    = vfc_q;
        den_d    = 1'b0;
        fv_d     = 1'b0;
        // A flag raised in the same cycle as clear_err wins because the set below overrides this.
        err_to_d = err_to_q & ~clear_err;
        err_ov_d = err_ov_q & ~clear_err;

        case (state_q)
            S_IDLE: begin
                if (eoc) begin
                    state_d = S_REQ;
                    den_d   = 1'b1;
                end
            end
            S_REQ: begin
                if (eoc) err_ov_d = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eoc) err_ov_d = 1'b1;
                // drdy on the limit cycle still counts as a capture.
                if (drdy) begin
                    case (ch_q)
                        2'd0: begin
                            raw0_d  = do_in;
                            ch_d    = 2'd1;
                            state_d = S_IDLE;
                        end
                        2'd1: begin
                            raw1_d  = do_in;
                            ch_d    = 2'd2;
                            state_d = S_IDLE;
                        end
                        default: begin
                            // Third sample goes straight into the outputs so frame_valid and the new
                            // values appear together in the COMMIT cycle.
                            raw2_d  = do_in;
                            ch_d    = 2'd0;
                            state_d = S_COMMIT;
                            vout_d  = raw1_q;
                            vfc_d   = (raw0_q >= do_in) ? (raw0_q - do_in) : 16'h0000;
                            fv_d    = 1'b1;
                        end
                    endcase
                end else if (cnt_q == CNT_LIMIT) begin
                    err_to_d = 1'b1;
                    ch_d     = 2'd0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // COMMIT does not start a new read; an eoc here is an overrun.
                if (eoc) err_ov_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ch_q     <= 2'd0;
            cnt_q    <= '0;
            raw0_q   <= 16'h0000;
            raw1_q   <= 16'h0000;
            raw2_q   <= 16'h0000;
            vout_q   <= 16'h0000;
            vfc_q    <= 16'h0000;
            den_q    <= 1'b0;
            fv_q     <= 1'b0;
            err_to_q <= 1'b0;
            err_ov_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            raw0_q   <= raw0_d;
            raw1_q   <= raw1_d;
            raw2_q   <= raw2_d;
            vout_q   <= vout_d;
            vfc_q    <= vfc_d;
            den_q    <= den_d;
            fv_q     <= fv_d;
            err_to_q <= err_to_d;
            err_ov_q <= err_ov_d;
        end
    end

    assign den         = den_q;
    assign vout        = vout_q;
    assign vfc         = vfc_q;
    assign frame_valid = fv_q;
    assign err_timeout = err_to_q;
    assign err_overrun = err_ov_q;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Purpose: directed self-checking bench for adc_frame_capture.
// Latency: inputs change 1 ns after a rising edge and outputs are sampled at that same point.
// Backpressure: none; every wait is a fixed number of cycles.
module tb_adc_frame_capture;

    logic        clk;
    logic        rst_n;
    logic        eoc;
    logic        drdy;
    logic [15:0] do_in;
    logic        clear_err;
    logic        den;
    logic [6:0]  daddr;
    logic [15:0] vout;
    logic [15:0] vfc;
    logic        frame_valid;
    logic        err_timeout;
    logic        err_overrun;

    int n_assert = 0;
    int n_fail   = 0;

    adc_frame_capture dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .eoc         (eoc),
        .drdy        (drdy),
        .do_in       (do_in),
        .clear_err   (clear_err),
        .den         (den),
        .daddr       (daddr),
        .vout        (vout),
        .vfc         (vfc),
        .frame_valid (frame_valid),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One DRP read: eoc, den check, drdy d cycles after den. Returns in the cycle after the capture edge.
    task automatic do_read(input string tag, input logic [6:0] exp_addr, input logic [15:0] data, input int d);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        check({tag, "_den"}, den, 1);
        check({tag, "_daddr"}, daddr, exp_addr);
        for (int i = 0; i < d; i++) begin
            tick();
            if (i == 0) check({tag, "_den_single"}, den, 0);
        end
        check({tag, "_daddr_stable"}, daddr, exp_addr);
        drdy  = 1'b1;
        do_in = data;
        tick();
        drdy  = 1'b0;
        do_in = 16'h0000;
    endtask

    initial begin
        int fv_seen;
        rst_n     = 1'b0;
        eoc       = 1'b0;
        drdy      = 1'b0;
        do_in     = 16'h0000;
        clear_err = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_den", den, 0);
        check("rst_fv", frame_valid, 0);
        check("rst_vout", vout, 0);
        check("rst_vfc", vfc, 0);
        check("rst_err_to", err_timeout, 0);
        check("rst_err_ov", err_overrun, 0);
        check("rst_daddr", daddr, 7'h17);
        rst_n = 1'b1;
        tick();

        // Normal frame
        do_read("n0", 7'h17, 16'h8000, 3);
        check("n0_fv", frame_valid, 0);
        do_read("n1", 7'h1E, 16'h5000, 3);
        check("n1_fv", frame_valid, 0);
        do_read("n2", 7'h1F, 16'h2000, 3);
        check("n_fv", frame_valid, 1);
        check("n_vout", vout, 16'h5000);
        check("n_vfc", vfc, 16'h6000);
        tick();
        check("n_fv_one", frame_valid, 0);
        check("n_vout_hold", vout, 16'h5000);
        check("n_vfc_hold", vfc, 16'h6000);

        // Saturation: ch0 < ch2
        do_read("s0", 7'h17, 16'h1000, 3);
        do_read("s1", 7'h1E, 16'h4444, 3);
        do_read("s2", 7'h1F, 16'h3000, 3);
        check("s_fv", frame_valid, 1);
        check("s_vout", vout, 16'h4444);
        check("s_vfc", vfc, 16'h0000);
        tick();

        // Timeout on the second read
        do_read("t0", 7'h17, 16'hAAAA, 3);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        check("t1_den", den, 1);
        check("t1_daddr", daddr, 7'h1E);
        fv_seen = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (frame_valid) fv_seen++;
        end
        check("t_not_yet", err_timeout, 0);
        tick();
        if (frame_valid) fv_seen++;
        check("t_err", err_timeout, 1);
        check("t_no_fv", fv_seen, 0);
        check("t_vout", vout, 16'h4444);
        check("t_vfc", vfc, 16'h0000);
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("t_clear", err_timeout, 0);

        // drdy exactly on the limit cycle is a capture; ch restarted at 0 after the timeout
        do_read("l0", 7'h17, 16'h9000, 64);
        check("l_no_err", err_timeout, 0);
        do_read("l1", 7'h1E, 16'h7000, 3);
        do_read("l2", 7'h1F, 16'h1000, 3);
        check("l_fv", frame_valid, 1);
        check("l_vout", vout, 16'h7000);
        check("l_vfc", vfc, 16'h8000);
        check("l_no_err2", err_timeout, 0);
        tick();

        // Overrun: eoc one cycle after den
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        check("o_den", den, 1);
        tick();
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        check("o_den_r2", den, 0);
        check("o_err", err_overrun, 1);
        tick();
        check("o_den_r3", den, 0);
        drdy  = 1'b1;
        do_in = 16'h1234;
        tick();
        drdy  = 1'b0;
        do_in = 16'h0000;
        check("o_den_after", den, 0);
        do_read("o1", 7'h1E, 16'h0100, 3);
        do_read("o2", 7'h1F, 16'h0034, 3);
        check("o_fv", frame_valid, 1);
        check("o_vout", vout, 16'h0100);
        check("o_vfc", vfc, 16'h1200);
        check("o_sticky", err_overrun, 1);
        tick();

        // Clear race: clear_err with a new overrun, then clear_err alone
        eoc = 1'b1;
        tick();
        check("c_den", den, 1);
        clear_err = 1'b1;
        tick();
        eoc = 1'b0;
        check("c_race", err_overrun, 1);
        tick();
        clear_err = 1'b0;
        check("c_cleared", err_overrun, 0);
        drdy  = 1'b1;
        do_in = 16'h2222;
        tick();
        drdy  = 1'b0;
        do_in = 16'h0000;

        // Reset mid-WAIT with ch=1, with an overrun flag pending
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        check("r_daddr", daddr, 7'h1E);
        tick();
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        check("r_ov_pre", err_overrun, 1);
        rst_n = 1'b0;
        #1;
        check("r_vout", vout, 0);
        check("r_vfc", vfc, 0);
        check("r_err_ov", err_overrun, 0);
        check("r_err_to", err_timeout, 0);
        check("r_fv", frame_valid, 0);
        check("r_den", den, 0);
        check("r_daddr_ch0", daddr, 7'h17);
        tick();
        rst_n = 1'b1;
        tick();
        drdy  = 1'b1;
        do_in = 16'hBEEF;
        tick();
        drdy  = 1'b0;
        do_in = 16'h0000;
        tick();
        check("r_drdy_fv", frame_valid, 0);
        check("r_drdy_vout", vout, 0);
        check("r_drdy_err", {err_timeout, err_overrun}, 0);
        do_read("r0", 7'h17, 16'h0F00, 3);
        check("r0_fv", frame_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
